// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity modes and the width helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

   // Counter width for 0..value-1; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned w;
      w = 0;
      while ((w < 31) && ((32'd1 << w) < value)) w++;
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; tick marks the last clk of each serial bit.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned    CNT_W    = clog2_min1(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops one FIFO word per frame and shifts it out on tx
// as start, LSB-first data, optional parity and stop bits.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [DATA_BITS-1:0] fifo_rd_data,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int unsigned      BIT_W     = clog2_min1(DATA_BITS);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic             PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

   uart_state_e          state, state_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx, data_q;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
   logic                 tx_nx, tick, baud_clear, parity_bit;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (tick)
   );

   // Parity comes from the unshifted copy taken in LOAD.
   assign parity_bit = (^data_q) ^ PAR_MODE;

   // Next-state, pop strobe and done strobe; tx is registered from the next state.
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      bit_cnt_nx = bit_cnt;
      fifo_rd_en = 1'b0;
      tx_done    = 1'b0;
      baud_clear = 1'b0;
      tx_nx      = 1'b1;

      case (state)
         IDLE: begin
            baud_clear = 1'b1;
            if (enable && !fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_nx   = LOAD;
            end
         end
         LOAD: begin
            baud_clear = 1'b1;
            shreg_nx   = fifo_rd_data;
            bit_cnt_nx = '0;
            state_nx   = START;
         end
         START: begin
            if (tick) state_nx = DATA;
         end
         DATA: begin
            if (tick) begin
               shreg_nx = shreg >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_cnt_nx = '0;
                  state_nx   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_nx = bit_cnt + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (tick) state_nx = STOP;
         end
         STOP: begin
            if (tick) begin
               if (bit_cnt == STOP_LAST) begin
                  tx_done    = 1'b1;
                  bit_cnt_nx = '0;
                  state_nx   = IDLE;
               end else begin
                  bit_cnt_nx = bit_cnt + BIT_W'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // A word popped during reset would be lost, so reset blocks the pop.
      if (rst) begin
         fifo_rd_en = 1'b0;
         tx_done    = 1'b0;
      end

      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shreg_nx[0];
         PARITY:  tx_nx = parity_bit;
         default: tx_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         data_q  <= '0;
         bit_cnt <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         bit_cnt <= bit_cnt_nx;
         tx      <= tx_nx;
         busy    <= (state_nx != IDLE);
         if (state == LOAD) data_q <= fifo_rd_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench: three engine variants (8N1, 8E2, 8O2) share one FIFO model
// and are compared cycle by cycle against a frame-level schedule model.
module tb_uart_tx_engine;

   localparam int unsigned C = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] en;
   logic       fifo_empty;
   logic [7:0] rd_data;
   logic [2:0] rd_en, tx, busy, done;

   logic [7:0] fmem [0:255];
   int         wp = 0;
   int         rp = 0;

   int   checks = 0;
   int   errors = 0;
   int   pops, pop1, pop2, done_cnt, done1, busy_cnt, stop_hi;
   logic par_seen;

   always #5 clk = ~clk;

   uart_tx_engine #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en[0]),
      .fifo_rd_data(rd_data), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));

   uart_tx_engine #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
      .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en[1]),
      .fifo_rd_data(rd_data), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));

   uart_tx_engine #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
      .clk(clk), .rst(rst), .enable(en[2]), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en[2]),
      .fifo_rd_data(rd_data), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

   // FIFO read side: registered data, valid the cycle after an accepted pop.
   assign fifo_empty = (rp >= wp);
   always @(posedge clk) begin
      if ((|rd_en) && (rp < wp)) begin
         rd_data <= fmem[rp[7:0]];
         rp      <= rp + 1;
      end
   end

   function automatic int pe_of(input int d);
      return (d == 0) ? 0 : 1;
   endfunction

   function automatic int odd_of(input int d);
      return (d == 2) ? 1 : 0;
   endfunction

   function automatic int sb_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic int frame_len(input int d);
      return (1 + 8 + pe_of(d) + sb_of(d)) * int'(C);
   endfunction

   // Line level j cycles after the pop: IDLE, LOAD, then one frame bit every C cycles.
   function automatic logic frame_tx(input int d, input logic [7:0] w, input int j);
      int b;
      if (j < 2) return 1'b1;
      b = (j - 2) / int'(C);
      if (b == 0) return 1'b0;
      if (b <= 8) return w[b-1];
      if ((pe_of(d) == 1) && (b == 9)) return 1'(($countones(w) + odd_of(d)) % 2);
      return 1'b1;
   endfunction

   task automatic push(input logic [7:0] w);
      fmem[wp[7:0]] = w;
      wp++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive one DUT for ncyc cycles (enable low in [off_t,on_t), rst pulse at rst_t)
   // and compare every cycle against the frame schedule model.
   task automatic run(input int d, input int ncyc, input int off_t, input int on_t, input int rst_t);
      int         mrp, p, j, f, run1;
      logic       active, bad, r, e_rd, e_tx, e_busy, e_done;
      logic [7:0] w;
      logic [2:0] e_rdv, e_txv, e_busyv, e_donev;
      f = frame_len(d);
      mrp = rp; p = 0; run1 = 0; active = 1'b0; bad = 1'b0; w = '0;
      pops = 0; pop1 = -1; pop2 = -1; done_cnt = 0; done1 = -1; busy_cnt = 0; stop_hi = -1;
      par_seen = 1'bx;
      for (int t = 0; t < ncyc; t++) begin
         @(negedge clk);
         r     = (t == rst_t);
         rst   = r;
         en    = '0;
         en[d] = !((t >= off_t) && (t < on_t));
         #1;
         if (active && ((t - p) >= f + 2)) active = 1'b0;
         if (!active) begin
            e_rd = en[d] && !r && (mrp < wp);
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            if (e_rd) begin
               active = 1'b1; p = t; w = fmem[mrp[7:0]]; mrp++;
            end
         end else begin
            j      = t - p;
            e_rd   = 1'b0;
            e_tx   = frame_tx(d, w, j);
            e_busy = 1'b1;
            e_done = (j == f + 1) && !r;
         end
         e_rdv   = e_rd ? (3'b001 << d) : 3'b000;
         e_txv   = 3'b111; e_txv[d]   = e_tx;
         e_busyv = 3'b000; e_busyv[d] = e_busy;
         e_donev = 3'b000; e_donev[d] = e_done;
         if (!bad) begin
            checks++;
            if ((rd_en !== e_rdv) || (tx !== e_txv) || (busy !== e_busyv) || (done !== e_donev)) begin
               errors++;
               bad = 1'b1;
               $display("FAIL trace dut%0d cycle %0d: rd_en=%b tx=%b busy=%b done=%b, expected rd_en=%b tx=%b busy=%b done=%b",
                        d, t, rd_en, tx, busy, done, e_rdv, e_txv, e_busyv, e_donev);
            end
         end
         if (r) active = 1'b0;
         if (rd_en[d]) begin
            pops++;
            if (pop1 < 0) pop1 = t; else if (pop2 < 0) pop2 = t;
         end
         if (busy[d]) busy_cnt++;
         run1 = tx[d] ? run1 + 1 : 0;
         if (done[d]) begin
            done_cnt++;
            if (done1 < 0) begin done1 = t; stop_hi = run1; end
         end
         if ((pop1 >= 0) && (t == pop1 + 2 + 9 * int'(C))) par_seen = tx[d];
      end
      rst = 1'b0;
      en  = '0;
   endtask

   task automatic test_reset();
      push(8'hA5);
      @(negedge clk);
      rst = 1'b1;
      en  = 3'b111;
      @(negedge clk);
      #1;
      checks++;
      if ({tx, busy, done} !== {3'b111, 3'b000, 3'b000}) begin
         errors++;
         $display("FAIL reset_outputs: tx/busy/done=%b, expected %b", {tx, busy, done}, {3'b111, 6'b0});
      end
      checks++;
      if (rd_en !== 3'b000) begin
         errors++;
         $display("FAIL reset_no_pop: rd_en=%b, expected 000", rd_en);
      end
      @(negedge clk);
      rst = 1'b0;
      en  = '0;
   endtask

   task automatic test_single_byte();
      do_reset();
      run(0, 50, 1000, 1000, -1);
      checks++;
      if (pops !== 1) begin errors++; $display("FAIL single_pops: got %0d, expected 1", pops); end
      checks++;
      if (busy_cnt !== 41) begin errors++; $display("FAIL single_busy_len: got %0d, expected 41", busy_cnt); end
      checks++;
      if (done1 - (pop1 + 1) !== 40) begin
         errors++; $display("FAIL single_done_after_load: got %0d, expected 40", done1 - (pop1 + 1));
      end
   endtask

   task automatic test_back_to_back();
      push(8'h00);
      push(8'hFF);
      do_reset();
      run(0, 100, 1000, 1000, -1);
      checks++;
      if (pops !== 2) begin errors++; $display("FAIL b2b_pops: got %0d, expected 2", pops); end
      checks++;
      if (pop2 - pop1 !== 42) begin errors++; $display("FAIL b2b_pop_spacing: got %0d, expected 42", pop2 - pop1); end
      checks++;
      if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt); end
   endtask

   task automatic test_empty();
      do_reset();
      run(0, 200, 1000, 1000, -1);
      checks++;
      if ((pops !== 0) || (busy_cnt !== 0)) begin
         errors++; $display("FAIL empty_idle: pops=%0d busy=%0d, expected 0 and 0", pops, busy_cnt);
      end
   endtask

   task automatic test_parity();
      push(8'h07);
      do_reset();
      run(1, 60, 1000, 1000, -1);
      checks++;
      if (par_seen !== 1'b1) begin errors++; $display("FAIL parity_even: got %b, expected 1", par_seen); end
      push(8'h07);
      do_reset();
      run(2, 60, 1000, 1000, -1);
      checks++;
      if (par_seen !== 1'b0) begin errors++; $display("FAIL parity_odd: got %b, expected 0", par_seen); end
      checks++;
      if (stop_hi !== 8) begin errors++; $display("FAIL two_stop_high: got %0d, expected 8", stop_hi); end
      checks++;
      if (done1 - pop1 - 1 !== 48) begin errors++; $display("FAIL parity_frame_len: got %0d, expected 48", done1 - pop1 - 1); end
   endtask

   task automatic test_reset_mid_frame();
      push(8'h3C);
      push(8'h5A);
      do_reset();
      run(0, 70, 1000, 1000, 19);
      checks++;
      if ((pops !== 2) || (pop2 !== 20)) begin
         errors++; $display("FAIL rst_mid_restart: pops=%0d second_pop=%0d, expected 2 and 20", pops, pop2);
      end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL rst_mid_done_count: got %0d, expected 1", done_cnt); end
   endtask

   task automatic test_enable_drop();
      push(8'($urandom));
      push(8'($urandom));
      do_reset();
      run(0, 170, 3, 120, -1);
      checks++;
      if ((pops !== 2) || (pop2 !== 120)) begin
         errors++; $display("FAIL enable_drop_pops: pops=%0d second_pop=%0d, expected 2 and 120", pops, pop2);
      end
      checks++;
      if (done_cnt !== 2) begin errors++; $display("FAIL enable_drop_done: got %0d, expected 2", done_cnt); end
   endtask

   task automatic test_random();
      int d, n, off_t, on_t, rst_t;
      for (int it = 0; it < 8; it++) begin
         d     = int'($urandom_range(0, 2));
         n     = int'($urandom_range(1, 3));
         off_t = int'($urandom_range(0, 60));
         on_t  = off_t + int'($urandom_range(0, 80));
         rst_t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 100)) : -1;
         for (int k = 0; k < n; k++) push(8'($urandom));
         do_reset();
         run(d, on_t + (n + 2) * 55, off_t, on_t, rst_t);
         checks++;
         if (rp !== wp) begin
            errors++; $display("FAIL random_drain it%0d: popped up to %0d, expected %0d", it, rp, wp);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = '0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_empty();
      test_parity();
      test_reset_mid_frame();
      test_enable_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
